// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the MEMORY stage: one outstanding load/store, valid/ready on both sides.
// Optional DMEM_MISALIGN_CHECK_EN: flag addr[1:0] != 0 as an error and suppress the store.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;
    logic               wr_q, wr_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0]        mem [DEPTH];

    logic               commit_c;
    logic               err_c;
    logic               cur_write_c;
    logic [31:0]        cur_addr_c;
    logic [31:0]        cur_wdata_c;
    logic [IDX_W-1:0]   mem_idx_c;
    logic               mem_we_c;

    // With zero wait states the commit edge is the accept edge, so use the live request.
    assign cur_write_c = (state_q == IDLE) ? req_write : wr_q;
    assign cur_addr_c  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata_c = (state_q == IDLE) ? req_wdata : wdata_q;
    assign mem_idx_c   = cur_addr_c[IDX_W+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign err_c = (|cur_addr_c[31:IDX_W+2]) | (cur_addr_c[1:0] != 2'b00);
`else
    logic addr_lsb_unused_c;
    assign addr_lsb_unused_c = ^cur_addr_c[1:0];
    assign err_c = |cur_addr_c[31:IDX_W+2];
`endif

    // Next-state, capture and commit decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        commit_c     = 1'b0;
        mem_we_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d  = RESP;
                    commit_c = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit_c) begin
            resp_valid_d = 1'b1;
            resp_err_d   = err_c;
            resp_rdata_d = (err_c || cur_write_c) ? 32'h0 : mem[mem_idx_c];
            mem_we_c     = cur_write_c && !err_c;
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_idx_c] <= cur_wdata_c;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, backpressure/reset sequences, zero-wait instance and random traffic vs a word-map model.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int WAITC = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        f_req_valid, f_req_write;
    logic [31:0] f_req_addr, f_req_wdata;
    logic        f_req_ready, f_resp_valid, f_resp_err;
    logic [31:0] f_resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] mdl [int unsigned];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_fast (
        .clk(clk), .rst_n(rst_n),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .resp_valid(f_resp_valid), .resp_ready(1'b1),
        .resp_rdata(f_resp_rdata), .resp_err(f_resp_err)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          delay;
    } vec_t;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic mdl_err(input logic [31:0] a);
        return (a >= 32'(DEPTH * 4)) || (MIS && (a[1:0] != 2'b00));
    endfunction

    function automatic void mdl_update(input logic w, input logic [31:0] a, input logic [31:0] d);
        if (w && !mdl_err(a)) mdl[32'(a >> 2)] = d;
    endfunction

    // One full transaction on the main instance, with latency and hold-stability checks.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int delay, input bit stray,
                           output logic [31:0] rd, output logic er);
        int  k;
        bit  hold_bad;
        rd = '0;
        er = 1'b0;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin step; k++; end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready never rose for addr %h", a);
            req_valid = 1'b0;
            return;
        end
        step;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'hFFFF_FFF0; req_wdata = '0;
        k = 0;
        while (!resp_valid && k < 50) begin step; k++; end
        chk("latency", 64'(k), 64'(WAITC));
        rd = resp_rdata;
        er = resp_err;
        hold_bad = 1'b0;
        for (int i = 0; i < delay; i++) begin
            if (stray) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
            end
            step;
            if (!resp_valid || req_ready || resp_rdata !== rd || resp_err !== er) hold_bad = 1'b1;
        end
        if (delay > 0) chk("hold", 64'(hold_bad), 64'(0));
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step;
        resp_ready = 1'b0;
        chk("release", {29'h0, resp_valid, req_ready, resp_err, resp_rdata}, {29'h0, 1'b0, 1'b1, 1'b0, 32'h0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt[12];
        logic [31:0] rd;
        logic        er;
        int          k, prev;
        logic        fw[5];
        logic [31:0] fa[5], fd[5], fr[5];
        logic        fe[5];

        vt[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 0};
        vt[1]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 0};
        vt[2]  = '{1'b1, 32'h0,        32'h11111111, 32'h0,        1'b0, 1};
        vt[3]  = '{1'b1, 32'h400,      32'h22222222, 32'h0,        1'b1, 0};
        vt[4]  = '{1'b0, 32'h0,        32'h0,        32'h11111111, 1'b0, 2};
        vt[5]  = '{1'b0, 32'h400,      32'h0,        32'h0,        1'b1, 0};
        vt[6]  = '{1'b1, 32'h3FC,      32'h0CAFEF00, 32'h0,        1'b0, 0};
        vt[7]  = '{1'b0, 32'h3FC,      32'h0,        32'h0CAFEF00, 1'b0, 1};
        vt[8]  = '{1'b0, 32'h80000000, 32'h0,        32'h0,        1'b1, 0};
        vt[9]  = '{1'b1, 32'h20,       32'hA5A5A5A5, 32'h0,        1'b0, 0};
        vt[10] = '{1'b0, 32'h12,       32'h0,        MIS ? 32'h0 : 32'hDEADBEEF, MIS, 1};
        vt[11] = '{1'b0, 32'h20,       32'h0,        32'hA5A5A5A5, 1'b0, 0};

        // Reset with a request pending: nothing accepted until after release.
        rst_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
        resp_ready = 1'b0;
        f_req_valid = 1'b0; f_req_write = 1'b0; f_req_addr = '0; f_req_wdata = '0;
        step; step;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_valid", 64'(resp_valid), 64'(0));
        #3 rst_n = 1'b1;
        step;
        chk("post_rst", {62'h0, req_ready, resp_valid}, {62'h0, 1'b1, 1'b0});
        req_valid = 1'b0;
        step;
        chk("post_rst_idle", 64'(req_ready), 64'(1));

        foreach (vt[i]) begin
            run_txn(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].delay, 1'b0, rd, er);
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].exp_rdata));
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].exp_err));
            mdl_update(vt[i].wr, vt[i].addr, vt[i].wdata);
        end

        // Backpressure with stray requests that must not be taken.
        run_txn(1'b0, 32'h10, 32'h0, 5, 1'b1, rd, er);
        chk("bp_rdata", 64'(rd), 64'(32'hDEADBEEF));
        run_txn(1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("bp_no_stray", 64'(rd), 64'(32'hDEADBEEF));

        // Zero-wait instance: back-to-back ops, response the cycle after accept.
        fw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        fa = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h40};
        fd = '{32'hCAFE0000, 32'h0BADF00D, 32'h0, 32'h0, 32'h0};
        fr = '{32'h0, 32'h0, 32'hCAFE0000, 32'h0BADF00D, 32'h0};
        fe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        prev = 0;
        f_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f_req_write = fw[i]; f_req_addr = fa[i]; f_req_wdata = fd[i];
            k = 0;
            while (!f_req_ready && k < 20) begin step; k++; end
            if (i > 0) chk("fast_spacing", 64'(cyc - prev), 64'(2));
            prev = cyc;
            step;
            chk("fast_valid", 64'(f_resp_valid), 64'(1));
            chk("fast_rdata", 64'(f_resp_rdata), 64'(fr[i]));
            chk("fast_err", 64'(f_resp_err), 64'(fe[i]));
            step;
        end
        f_req_valid = 1'b0;
        chk("fast_done", 64'(f_resp_valid), 64'(0));

        // Reset in WAIT discards the pending store.
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin step; k++; end
        step;
        req_valid = 1'b0;
        step;
        #2 rst_n = 1'b0;
        #1 chk("midrst_outs", {62'h0, req_ready, resp_valid}, 64'h0);
        #3 rst_n = 1'b1;
        step;
        run_txn(1'b0, 32'h20, 32'h0, 0, 1'b0, rd, er);
        chk("midrst_load", 64'(rd), 64'(32'hA5A5A5A5));

        // Misaligned store: error and suppressed with the check, word write without.
        run_txn(1'b1, 32'h22, 32'h77777777, 0, 1'b0, rd, er);
        chk("mis_store_err", 64'(er), 64'(MIS));
        mdl_update(1'b1, 32'h22, 32'h77777777);
        run_txn(1'b0, 32'h20, 32'h0, 0, 1'b0, rd, er);
        chk("mis_readback", 64'(rd), 64'(MIS ? 32'hA5A5A5A5 : 32'h77777777));

        // Random traffic against the word-map model.
        for (int n = 0; n < 40; n++) begin
            logic        w;
            logic [31:0] a, d, exp_rd;
            logic        exp_er;
            bit          known;
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            case ($urandom_range(0, 3))
                0: a = 32'($urandom_range(0, 15)) << 2;
                1: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                2: a = 32'h400 + 32'($urandom_range(0, 255));
                default: a = 32'h3F0 + (32'($urandom_range(0, 3)) << 2);
            endcase
            exp_er = mdl_err(a);
            known  = !exp_er && mdl.exists(32'(a >> 2));
            exp_rd = (exp_er || w) ? 32'h0 : (known ? mdl[32'(a >> 2)] : 32'h0);
            run_txn(w, a, d, $urandom_range(0, 3), 1'b0, rd, er);
            chk("rand_err", 64'(er), 64'(exp_er));
            if (w || exp_er || known) chk("rand_rdata", 64'(rd), 64'(exp_rd));
            mdl_update(w, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
